// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Time-multiplexed N-digit 7-segment display driver. A prescaler holds each
// digit on the shared segment bus for REFRESH_DIV clocks while the matching
// anode line is enabled. Digit codes, decimal points and the leading-zero
// enable are captured once per frame, so a display never shows a mix of two
// input values.
//
// Parameters:
//   NUM_DIGITS     - digits scanned (1..8)
//   REFRESH_DIV    - clocks each digit is driven (>= 1)
//   HEX_MODE       - 1: codes 10..15 show A b C d E F, 0: they show blank
//   SEG_ACTIVE_LOW - 1: seg/dp are low-true
//   AN_ACTIVE_LOW  - 1: an is low-true
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   en         - 1: scan the display, 0: blank and idle
//   digits_in  - packed 4-bit codes, digit i at [4i+3:4i], digit 0 rightmost
//   dp_in      - decimal point per digit
//   lz_blank   - enable leading-zero suppression
//   seg        - segments {a,b,c,d,e,f,g}, a = seg[6]
//   dp         - decimal point of the active digit
//   an         - one-hot digit enable, bit i = digit i
//   frame_tick - one-cycle pulse registered together with digit 0 of a frame
// ---------------------------------------------------------------------------
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic                  SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic                  AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = {7{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_INV}};

  localparam logic [IW-1:0] LAST_INDEX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRESC = PW'(REFRESH_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           index_q, index_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [4*NUM_DIGITS-1:0] snapDigits_q, snapDigits_d;
  logic [NUM_DIGITS-1:0]   snapDp_q, snapDp_d;
  logic                    snapLz_q, snapLz_d;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frameTick_q, frameTick_d;

  logic [NUM_DIGITS-1:0]   blankMask;
  logic                    zeroRun;
  logic [3:0]              activeCode;
  logic                    activeDp;
  logic                    activeBlank;
  logic [NUM_DIGITS-1:0]   anHot;

  // Segment pattern (a..g, 1 = lit) for one digit code. Hex letters are
  // only produced when HEX_MODE is set; otherwise codes 10..15 go dark.
  function automatic logic [6:0] decodeDigit(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'h0:    pattern = 7'b1111110;
      4'h1:    pattern = 7'b0110000;
      4'h2:    pattern = 7'b1101101;
      4'h3:    pattern = 7'b1111001;
      4'h4:    pattern = 7'b0110011;
      4'h5:    pattern = 7'b1011011;
      4'h6:    pattern = 7'b1011111;
      4'h7:    pattern = 7'b1110000;
      4'h8:    pattern = 7'b1111111;
      4'h9:    pattern = 7'b1111011;
      4'hA:    pattern = 7'b1110111;
      4'hB:    pattern = 7'b0011111;
      4'hC:    pattern = 7'b1001110;
      4'hD:    pattern = 7'b0111101;
      4'hE:    pattern = 7'b1001111;
      default: pattern = 7'b1000111;
    endcase
    if ((HEX_MODE == 0) && (code > 4'h9)) begin
      pattern = 7'b0000000;
    end
    return pattern;
  endfunction

  // Leading-zero mask from the snapshot. Walking down from the top digit,
  // a digit is blanked while every digit from the top down to it is zero.
  // Digit 0 is never part of the walk, so a value of zero still shows "0".
  always_comb begin
    blankMask = '0;
    zeroRun   = snapLz_q;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeroRun      = zeroRun & (snapDigits_q[4*i +: 4] == 4'h0);
      blankMask[i] = zeroRun;
    end
  end

  // Pick out the code, decimal point, blanking flag and anode bit of the
  // digit currently selected by the scan index.
  always_comb begin
    activeCode  = '0;
    activeDp    = 1'b0;
    activeBlank = 1'b0;
    anHot       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index_q == IW'(i)) begin
        activeCode  = snapDigits_q[4*i +: 4];
        activeDp    = snapDp_q[i];
        activeBlank = blankMask[i];
        anHot[i]    = 1'b1;
      end
    end
  end

  // Next-state logic. Dropping en wins over everything in SCAN. Entering
  // SCAN and wrapping the index back to digit 0 both take a fresh snapshot
  // so that one frame always shows one consistent input value.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    presc_d      = presc_q;
    snapDigits_d = snapDigits_q;
    snapDp_d     = snapDp_q;
    snapLz_d     = snapLz_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d      = SCAN;
          index_d      = '0;
          presc_d      = '0;
          snapDigits_d = digits_in;
          snapDp_d     = dp_in;
          snapLz_d     = lz_blank;
        end
      end
      default: begin
        if (!en) begin
          state_d = IDLE;
          index_d = '0;
          presc_d = '0;
        end else if (presc_q == LAST_PRESC) begin
          presc_d = '0;
          if (index_q == LAST_INDEX) begin
            index_d      = '0;
            snapDigits_d = digits_in;
            snapDp_d     = dp_in;
            snapLz_d     = lz_blank;
          end else begin
            index_d = index_q + IW'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    endcase
  end

  // Output values for the next edge. They are built from the current index,
  // so the display lags the index by one clock, and an/seg/dp change on the
  // same edge. frame_tick marks the first cycle digit 0 of a frame is shown.
  always_comb begin
    seg_d       = SEG_OFF;
    dp_d        = SEG_INV;
    an_d        = AN_OFF;
    frameTick_d = 1'b0;
    if (state_q == SCAN) begin
      seg_d       = (activeBlank ? 7'b0000000 : decodeDigit(activeCode)) ^ SEG_OFF;
      dp_d        = activeDp ^ SEG_INV;
      an_d        = anHot ^ AN_OFF;
      frameTick_d = (index_q == '0) && (presc_q == '0);
    end
  end

  // Scan state, counters and snapshot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      index_q      <= '0;
      presc_q      <= '0;
      snapDigits_q <= '0;
      snapDp_q     <= '0;
      snapLz_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      presc_q      <= presc_d;
      snapDigits_q <= snapDigits_d;
      snapDp_q     <= snapDp_d;
      snapLz_q     <= snapLz_d;
    end
  end

  // Output registers. Reset drives every line to its inactive level at
  // once, independent of the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q       <= SEG_OFF;
      dp_q        <= SEG_INV;
      an_q        <= AN_OFF;
      frameTick_q <= 1'b0;
    end else begin
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      frameTick_q <= frameTick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frameTick_q;

endmodule
